dmem_lsu: RTL and testbench

- Load/store initiator for the data RAM. The RAM is word-wide, 32-entry, with registered address/data/output and an active-high write enable.
- Accepts one CPU memory request at a time and issues word reads/writes to the RAM, waiting out the RAM read latency.
- Extracts and extends byte/halfword loads; performs read-modify-write for byte/halfword stores.
- Sits between the multicycle datapath control and the data RAM.

---
 rtl/dmem_lsu.sv | 178 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-wide data RAM. It handles byte/half load extraction and read-modify-write for sub-word stores.
// The optional LSU_STATS_EN macro adds saturating ld_cnt/st_cnt/err_cnt outputs.
module dmem_lsu #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          ready,
  input  logic          op_st,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          err,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   st_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_st_q, op_st_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [1:0]       off_q, off_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      rdata_d, mem_addr_d, mem_wdata_d;
  logic             err_d;

  logic [31:0] addr_w;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, st_merge;

  assign addr_w     = 32'(addr);
  assign misaligned = (size == 2'b11) ||
                      ((size == 2'b01) && addr_w[0]) ||
                      ((size == 2'b10) && (addr_w[1:0] != 2'b00));

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    ld_byte  = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half  = mem_rdata[{off_q[1], 4'b0000} +: 16];
    st_merge = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
    if (size_q == 2'b00) st_merge[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 st_merge[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    op_st_d     = op_st_q;
    size_d      = size_q;
    sext_d      = sext_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    rdata_d     = rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_st_d    = op_st;
          size_d     = size;
          sext_d     = sext;
          off_d      = addr_w[1:0];
          wdata_d    = wdata[15:0];
          wait_cnt_d = '0;
          mem_addr_d = {addr_w[31:2], 2'b00};
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (op_st && (size == 2'b10)) begin
            state_d     = WR;
            mem_wdata_d = wdata;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt_q == LAST_CNT) begin
          if (op_st_q) begin
            mem_wdata_d = st_merge;
            state_d     = WR;
          end else begin
            rdata_d = ld_ext;
            state_d = DONE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wait_cnt_q <= '0;
      op_st_q    <= 1'b0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready      <= (state_d == IDLE);
      done       <= (state_d == DONE);
      err        <= err_d;
      mem_we     <= (state_d == WR);
      rdata      <= rdata_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      wait_cnt_q <= wait_cnt_d;
      op_st_q    <= op_st_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef LSU_STATS_EN
  // Saturating completion counters, bumped at the end of the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt  <= '0;
      st_cnt  <= '0;
      err_cnt <= '0;
    end else if (done) begin
      if (err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (op_st_q) begin
        if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
      end else begin
        if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu. It surrounds the design with a latency-2 RAM and checks it against an array-based reference of memory contents.
module tb_dmem_lsu;
  localparam int unsigned RD_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst, req, ready, op_st, sext, done, err, mem_we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_STATS_EN
  logic [15:0] ld_cnt, st_cnt, err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.RD_LATENCY(RD_LATENCY), .AW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .op_st(op_st), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
    , .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
`endif
  );

  // RAM: one output register, so data for an address driven at edge N is sampled at edge N+2
  logic [31:0] ram [32];
  logic [31:0] rd_reg;
  logic        ram_ld_en;
  logic [4:0]  ram_ld_idx;
  logic [31:0] ram_ld_val;
  always_ff @(posedge clk) begin
    if (ram_ld_en)   ram[ram_ld_idx] <= ram_ld_val;
    else if (mem_we) ram[mem_addr[6:2]] <= mem_wdata;
    rd_reg <= ram[mem_addr[6:2]];
  end
  assign mem_rdata = rd_reg;

  // Reference model state
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rdata;

  task automatic predict(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int cyc, output logic e, output logic [31:0] rd,
                         output int wec, output logic [31:0] wed);
    int          idx;
    int          sh;
    logic [31:0] w, v, mask;
    idx = int'(a[6:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx];
    e   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    wec = 0;
    wed = 32'h0;
    if (e) begin
      cyc = 1;
    end else if (!st) begin
      cyc = 1 + int'(RD_LATENCY);
      if (sz == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      exp_rdata = v;
    end else if (sz == 2'd2) begin
      cyc = 2;
      wec = 1;
      wed = wd;
      ref_mem[idx] = wd;
    end else begin
      cyc  = 2 + int'(RD_LATENCY);
      wec  = 1 + int'(RD_LATENCY);
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      wed  = (w & ~mask) | ((wd << sh) & mask);
      ref_mem[idx] = wed;
    end
    rd = exp_rdata;
  endtask

  // Issue one request from a negedge and observe it until one cycle past done
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int done_cyc, output logic e, output logic [31:0] rd,
                        output int we_cnt, output int we_cyc, output logic [31:0] we_data,
                        output logic [31:0] we_addr, output int busy_rdy, output logic rdy_after);
    done_cyc = 0; e = 1'b0; rd = 32'h0; we_cnt = 0; we_cyc = 0;
    we_data = 32'h0; we_addr = 32'h0; busy_rdy = 0;
    op_st = st; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready) busy_rdy++;
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_data = mem_wdata; we_addr = mem_addr;
      end
      if (done) begin
        done_cyc = c; e = err; rd = rdata;
        break;
      end
    end
    @(negedge clk);
    rdy_after = ready;
  endtask

  task automatic init_ram();
    logic [31:0] v;
    rst = 1'b1; req = 1'b0; op_st = 1'b0; size = 2'd0; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0; ram_ld_en = 1'b0; ram_ld_idx = 5'd0; ram_ld_val = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      v = (i == 1) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = v;
      ram_ld_en = 1'b1; ram_ld_idx = 5'(i); ram_ld_val = v;
      @(negedge clk);
    end
    ram_ld_en = 1'b0;
    exp_rdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [102:0] got, want;
    @(negedge clk);
    got  = {ready, done, err, mem_we, rdata, mem_addr, mem_wdata, 3'b000};
    want = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000};
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_state got %h want %h", got, want);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic st; logic [1:0] sz; logic sx; logic [31:0] a; logic [31:0] wd;
    int cyc; logic e; logic [31:0] rd; int wec; logic [31:0] wed;
  } vec_t;

  task automatic test_plan_vectors();
    vec_t tbl [8];
    int dc, wc, wy, br, pc, pw;
    logic e, ra, pe;
    logic [31:0] rd, wdat, wadr, prd, pwd;
    tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h07, 32'h0,        3, 1'b0, 32'hFFFF_FF88, 0, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h07, 32'h0,        3, 1'b0, 32'h0000_0088, 0, 32'h0};
    tbl[2] = '{1'b0, 2'd1, 1'b1, 32'h04, 32'h0,        3, 1'b0, 32'hFFFF_AABB, 0, 32'h0};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        3, 1'b0, 32'h8899_AABB, 0, 32'h0};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 32'h05, 32'h5A,       4, 1'b0, 32'h8899_AABB, 3, 32'h8899_5ABB};
    tbl[5] = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h1234_5678, 2, 1'b0, 32'h8899_AABB, 1, 32'h1234_5678};
    tbl[6] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        3, 1'b0, 32'h1234_5678, 0, 32'h0};
    tbl[7] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        1, 1'b1, 32'h1234_5678, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      predict(tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, pc, pe, prd, pw, pwd);
      run_op(tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, dc, e, rd, wc, wy, wdat, wadr, br, ra);
      n_checks++;
      if ({dc, 31'h0, e, rd} !== {tbl[i].cyc, 31'h0, tbl[i].e, tbl[i].rd}) begin
        n_errors++;
        $display("FAIL plan%0d_done cyc/err/rdata got %0d/%b/%h want %0d/%b/%h",
                 i, dc, e, rd, tbl[i].cyc, tbl[i].e, tbl[i].rd);
      end
      n_checks++;
      if (wc !== ((tbl[i].wec != 0) ? 1 : 0) || wy !== tbl[i].wec ||
          (tbl[i].wec != 0 && (wdat !== tbl[i].wed || wadr !== {tbl[i].a[31:2], 2'b00}))) begin
        n_errors++;
        $display("FAIL plan%0d_write n/cyc/data/addr got %0d/%0d/%h/%h want cyc %0d data %h",
                 i, wc, wy, wdat, wadr, tbl[i].wec, tbl[i].wed);
      end
      n_checks++;
      if (br !== 0 || ra !== 1'b1) begin
        n_errors++;
        $display("FAIL plan%0d_ready busy_ready=%0d after=%b want 0/1", i, br, ra);
      end
    end
`ifdef LSU_STATS_EN
    n_checks++;
    if ({ld_cnt, st_cnt, err_cnt} !== {16'd5, 16'd2, 16'd1}) begin
      n_errors++;
      $display("FAIL stats ld/st/err got %0d/%0d/%0d want 5/2/1", ld_cnt, st_cnt, err_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int dc, wc, wy, br, pc, pw;
    logic e, ra, pe, st, sx;
    logic [1:0] sz;
    logic [31:0] a, wd, rd, wdat, wadr, prd, pwd;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); sx = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom;
      predict(st, sz, sx, a, wd, pc, pe, prd, pw, pwd);
      run_op(st, sz, sx, a, wd, dc, e, rd, wc, wy, wdat, wadr, br, ra);
      n_checks++;
      if (dc !== pc || e !== pe || rd !== prd) begin
        n_errors++;
        $display("FAIL rand%0d_done st=%b sz=%0d a=%h cyc/err/rdata got %0d/%b/%h want %0d/%b/%h",
                 i, st, sz, a, dc, e, rd, pc, pe, prd);
      end
      n_checks++;
      if (wc !== ((pw != 0) ? 1 : 0) || wy !== pw ||
          (pw != 0 && (wdat !== pwd || wadr !== {a[31:2], 2'b00}))) begin
        n_errors++;
        $display("FAIL rand%0d_write n/cyc/data/addr got %0d/%0d/%h/%h want cyc %0d data %h",
                 i, wc, wy, wdat, wadr, pw, pwd);
      end
      n_checks++;
      if (br !== 0 || ra !== 1'b1) begin
        n_errors++;
        $display("FAIL rand%0d_ready busy_ready=%0d after=%b want 0/1", i, br, ra);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pc, pw;
    logic pe;
    logic [31:0] prd, pwd;
    logic [7:0] pat;
    logic [31:0] rds [2];
    int nd;
    predict(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, pc, pe, prd, pw, pwd);
    predict(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, pc, pe, prd, pw, pwd);
    pat = 8'h0; nd = 0;
    op_st = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h30; wdata = 32'h0; req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      pat[c] = done;
      if (done && nd < 2) begin rds[nd] = rdata; nd++; end
    end
    req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pat !== 8'b1000_1000) begin
      n_errors++;
      $display("FAIL b2b_done_pattern got %b want 10001000", pat);
    end
    n_checks++;
    if (nd !== 2 || rds[0] !== prd || rds[1] !== prd) begin
      n_errors++;
      $display("FAIL b2b_rdata n=%0d got %h/%h want %h", nd, rds[0], rds[1], prd);
    end
  endtask

  task automatic test_ignore_busy();
    int pc, pw, nd, nw;
    logic pe;
    logic [31:0] prd, pwd, wdat;
    predict(1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5_0001, pc, pe, prd, pw, pwd);
    nd = 0; nw = 0; wdat = 32'h0;
    op_st = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h40; wdata = 32'hA5A5_0001; req = 1'b1;
    @(posedge clk);
    #1 addr = 32'h44; wdata = 32'h5A5A_0002;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) req = 1'b0;
      if (done) nd++;
      if (mem_we) begin nw++; wdat = mem_wdata; end
    end
    n_checks++;
    if (nd !== 1 || nw !== 1 || wdat !== 32'hA5A5_0001) begin
      n_errors++;
      $display("FAIL busy_req_ignored dones=%0d writes=%0d data=%h want 1/1/a5a50001", nd, nw, wdat);
    end
  endtask

  task automatic test_reset_mid();
    int nd, nw;
    logic [2:0] st_now;
    nd = 0; nw = 0;
    op_st = 1'b1; size = 2'd1; sext = 1'b0; addr = 32'h0A; wdata = 32'h0000_BEEF; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    st_now = {ready, done, mem_we};
    rst = 1'b0;
    exp_rdata = 32'h0;
    n_checks++;
    if (st_now !== 3'b100 || rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_mid_state ready/done/we got %b rdata %h want 100/0", st_now, rdata);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (mem_we) nw++;
    end
    n_checks++;
    if (nd !== 0 || nw !== 0 || ram[2] !== ref_mem[2]) begin
      n_errors++;
      $display("FAIL rst_mid_abandon dones=%0d writes=%0d word=%h want 0/0/%h", nd, nw, ram[2], ref_mem[2]);
    end
  endtask

  task automatic test_ram_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL ram_image words_differing got %0d want 0", bad);
    end
  endtask

  initial begin
    init_ram();
    test_reset();
    test_plan_vectors();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_ram_image();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
